// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, read-valid strobe
// and sticky overflow/underflow flags. Optional first-word-fall-through mode: define FIFO_FWFT_EN.
module fifo_sync_flags #(
  parameter int data_width   = 8,
  parameter int depth_width  = 5,
  parameter int afull_level  = (1 << depth_width) - 4,
  parameter int aempty_level = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [depth_width:0]  count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << depth_width;
  localparam int CW    = depth_width + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(afull_level);
  localparam logic [CW-1:0] AEMPTY_C = CW'(aempty_level);

  logic [data_width-1:0] mem [DEPTH];
  logic [data_width-1:0] rd_data_reg;
  logic [CW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  full_reg, empty_reg, empty_next;
  logic                  afull_reg, aempty_reg;
  logic                  overflow_reg, underflow_reg;
  logic                  wr_accept, rd_accept, mem_rd;

  assign wr_accept   = wr_en && !full_reg;
  assign rd_accept   = rd_en && !empty_reg;
  assign wr_ptr_next = wr_ptr_reg + CW'(wr_accept);
  assign rd_ptr_next = rd_ptr_reg + CW'(mem_rd);

`ifdef FIFO_FWFT_EN
  // The head word lives in the output register; memory refills it when it is free or being popped.
  assign mem_rd     = (wr_ptr_reg != rd_ptr_reg) && (empty_reg || rd_accept);
  assign empty_next = !(mem_rd || (!empty_reg && !rd_accept));
  assign count_next = wr_ptr_next - rd_ptr_next + CW'(!empty_next);
  assign rd_valid   = !empty_reg;
`else
  logic rd_valid_reg;

  assign mem_rd     = rd_accept;
  assign count_next = wr_ptr_next - rd_ptr_next;
  assign empty_next = (count_next == '0);
  assign rd_valid   = rd_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= (count_next == DEPTH_C);
      empty_reg     <= empty_next;
      afull_reg     <= (count_next >= AFULL_C);
      aempty_reg    <= (count_next <= AEMPTY_C);
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_reg  <= (wr_en && full_reg) || (overflow_reg && !clr_err);
      underflow_reg <= (rd_en && empty_reg) || (underflow_reg && !clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr_reg[depth_width-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (mem_rd) begin
      rd_data_reg <= mem[rd_ptr_reg[depth_width-1:0]];
    end
  end

  assign rd_data      = rd_data_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags in standard mode: vector table, queue model and
// read-data scoreboard, plus fill/overflow/drain/wrap/reset sequences.
module tb_fifo_sync_flags;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AFULL = 28;
  localparam int AEMPTY = 4;

  logic          clk = 1'b0;
  logic          reset, wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  fifo_sync_flags #(.data_width(DW), .depth_width(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_q[$];
  logic [7:0] sb_q[$];
  logic       m_ovf, m_unf, m_rdv;
  logic [7:0] m_rd_data;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         exp_count;
    logic       exp_empty;
    logic       exp_unf;
    logic       exp_rdv;
    logic [7:0] exp_rdd;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
  endtask

  // Advance the reference model using the inputs present at this edge.
  task automatic model_edge();
    bit mfull, mempty, wacc, racc;
    if (reset) begin
      m_q.delete(); sb_q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0; m_rd_data = 8'h00;
    end else begin
      mfull  = (m_q.size() == DEPTH);
      mempty = (m_q.size() == 0);
      wacc   = wr_en && !mfull;
      racc   = rd_en && !mempty;
      m_rdv  = racc;
      if (racc) begin
        m_rd_data = m_q.pop_front();
        sb_q.push_back(m_rd_data);
      end
      if (wacc) m_q.push_back(wr_data);
      m_ovf = (wr_en && mfull) || (m_ovf && !clr_err);
      m_unf = (rd_en && mempty) || (m_unf && !clr_err);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = m_q.size();
    chk({tag, "_count"}, int'(count), n);
    chk({tag, "_full"}, int'(full), int'(n == DEPTH));
    chk({tag, "_empty"}, int'(empty), int'(n == 0));
    chk({tag, "_afull"}, int'(almost_full), int'(n >= AFULL));
    chk({tag, "_aempty"}, int'(almost_empty), int'(n <= AEMPTY));
    chk({tag, "_overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, "_underflow"}, int'(underflow), int'(m_unf));
    chk({tag, "_rd_valid"}, int'(rd_valid), int'(m_rdv));
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s_sb: rd_valid high with rd_data=%0h but no read outstanding", tag, rd_data);
      end else begin
        chk({tag, "_rd_data"}, int'(rd_data), int'(sb_q.pop_front()));
      end
    end else begin
      chk({tag, "_rd_hold"}, int'(rd_data), int'(m_rd_data));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h22};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'h33};
    vecs[8]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'h33};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 8'h44};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'h44};

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step("reset0");
    step("reset1");
    reset = 1'b0;

    // Short sequence with hand-computed expectations.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      step("vec");
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_underflow", i), int'(underflow), int'(vecs[i].exp_unf));
      chk($sformatf("vec%0d_rd_valid", i), int'(rd_valid), int'(vecs[i].exp_rdv));
      chk($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(vecs[i].exp_rdd));
    end

    // Fill 0x01..0x20 back to back.
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step("t1_reset");
    reset = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      step("t1_fill");
      chk($sformatf("t1_afull_at_%0d", i), int'(almost_full), int'(i >= AFULL));
    end
    chk("t1_full", int'(full), 1);
    chk("t1_count", int'(count), DEPTH);
    chk("t1_overflow", int'(overflow), 0);

    // Write while full, then clear.
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    step("t2_ovf");
    chk("t2_overflow_set", int'(overflow), 1);
    chk("t2_count_held", int'(count), DEPTH);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step("t2_clr");
    chk("t2_overflow_clr", int'(overflow), 0);

    // Drain all words in order, then an extra read.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step("t3_drain");
      chk($sformatf("t3_data_%0d", i), int'(rd_data), i);
      chk($sformatf("t3_valid_%0d", i), int'(rd_valid), 1);
    end
    chk("t3_empty", int'(empty), 1);
    chk("t3_aempty", int'(almost_empty), 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step("t3_extra");
    chk("t3_underflow", int'(underflow), 1);
    chk("t3_no_valid", int'(rd_valid), 0);

    // Hold 16 words while streaming 40 read+write cycles through the wrap.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step("t4_fill");
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      step("t4_stream");
      chk($sformatf("t4_count_%0d", i), int'(count), 16);
    end

    // Reset mid-stream at count 10 with a write pending.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step("t5_drain");
    end
    chk("t5_count10", int'(count), 10);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    reset = 1'b1;
    step("t5_reset");
    reset = 1'b0;
    chk("t5_count", int'(count), 0);
    chk("t5_empty", int'(empty), 1);
    chk("t5_full", int'(full), 0);
    chk("t5_underflow", int'(underflow), 0);
    chk("t5_rd_valid", int'(rd_valid), 0);
    chk("t5_rd_data", int'(rd_data), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step("t5_idle");
    chk("t5_wr_ignored", int'(count), 0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    step("t5_wr");
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step("t5_rd");
    chk("t5_post_data", int'(rd_data), 8'h5A);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step("t5_end");
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
